// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_mmio round-robin bus arbiter.
// Holds the FSM state encoding, the timeout read-data default and the grant-index width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // A single requester still needs a one-bit index to keep port widths legal.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_bus_arbiter_if.sv
// Native mem-bus link between the arbiter and the uart_mmio slave port.
// Handshake: the arbiter pulses s_mem_valid for exactly one cycle per transaction with
// addr/wdata/wstrb/instr stable; the slave answers later with a one-cycle s_mem_ready
// carrying s_mem_rdata. There is no backpressure on the strobe itself.
interface uart_bus_arbiter_if;
    logic        s_mem_valid;
    logic        s_mem_instr;
    logic [31:0] s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [3:0]  s_mem_wstrb;
    logic        s_mem_ready;
    logic [31:0] s_mem_rdata;

    modport master (
        output s_mem_valid, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb,
        input  s_mem_ready, s_mem_rdata
    );

    modport slave (
        input  s_mem_valid, s_mem_instr, s_mem_addr, s_mem_wdata, s_mem_wstrb,
        output s_mem_ready, s_mem_rdata
    );
endinterface

// File: rtl/uart_arb_rr_pick.sv
// Combinational rotating-priority encoder: returns the first asserted request at or
// after ptr, scanning upward modulo N. Kept standalone for reuse by other schedulers.
module uart_arb_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int W = grant_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);

    logic [W:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (W+1)'(i);
            if (cand >= (W+1)'(N)) begin
                cand = cand - (W+1)'(N);
            end
            if (!found && req[cand[W-1:0]]) begin
                found = 1'b1;
                index = cand[W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing one uart_mmio slave among NUM_MASTERS held-valid requesters,
// turning each request into a single-cycle slave strobe. Optional timeout: UART_ARB_TIMEOUT_EN.
module uart_bus_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          NUM_MASTERS    = 2,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT,
    localparam int         GW             = grant_width(NUM_MASTERS)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_MASTERS-1:0]    m_valid,
    input  logic [NUM_MASTERS-1:0]    m_instr,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [4*NUM_MASTERS-1:0]  m_wstrb,
    output logic [NUM_MASTERS-1:0]    m_ready,
    output logic [31:0]               m_rdata,
    uart_bus_arbiter_if.master        s_mem,
    output logic [GW-1:0]             grant_id,
    output logic                      busy,
    output logic                      timeout_err,
    output arb_state_t                dbg_state
);

    arb_state_t    state;
    logic [GW-1:0] rr_ptr;
    logic          pick_found;
    logic [GW-1:0] pick_idx;

    uart_arb_rr_pick #(
        .N (NUM_MASTERS),
        .W (GW)
    ) u_pick (
        .req   (m_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    assign dbg_state = state;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] to_cnt;
    logic          to_err;
    assign timeout_err = to_err;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state             <= ST_IDLE;
            rr_ptr            <= '0;
            grant_id          <= '0;
            busy              <= 1'b0;
            m_ready           <= '0;
            m_rdata           <= '0;
            s_mem.s_mem_valid <= 1'b0;
            s_mem.s_mem_instr <= 1'b0;
            s_mem.s_mem_addr  <= '0;
            s_mem.s_mem_wdata <= '0;
            s_mem.s_mem_wstrb <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt            <= '0;
            to_err            <= 1'b0;
`endif
        end else begin
            // Strobe and completion are pulses; only the transitions below raise them.
            s_mem.s_mem_valid <= 1'b0;
            m_ready           <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id          <= pick_idx;
                        s_mem.s_mem_instr <= m_instr[pick_idx];
                        s_mem.s_mem_addr  <= m_addr[32*pick_idx +: 32];
                        s_mem.s_mem_wdata <= m_wdata[32*pick_idx +: 32];
                        s_mem.s_mem_wstrb <= m_wstrb[4*pick_idx +: 4];
                        s_mem.s_mem_valid <= 1'b1;
                        busy              <= 1'b1;
                        state             <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (s_mem.s_mem_ready) begin
                        m_rdata <= s_mem.s_mem_rdata;
                        m_ready <= NUM_MASTERS'(1) << grant_id;
                        state   <= ST_RESP;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        m_rdata <= ERR_RDATA;
                        m_ready <= NUM_MASTERS'(1) << grant_id;
                        to_err  <= 1'b1;
                        state   <= ST_RESP;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
`endif
                    end
                end
                ST_RESP: begin
                    // Served master drops to lowest priority for the next arbitration.
                    rr_ptr <= (grant_id == GW'(NUM_MASTERS - 1)) ? '0 : grant_id + GW'(1);
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_bus_arbiter.md
Name: uart_bus_arbiter

Overview:
Round-robin arbiter that shares one uart_mmio slave port among NUM_MASTERS native mem-bus requesters, for example the CPU data port and a DMA/log engine. The UART slave performs side effects on every cycle in which mem_valid is high (RX pop, TX push), so the arbiter converts each master's held-valid request into a single-cycle slave strobe. It then waits for the slave's registered ready and returns the captured read data to the granted master.

Parameters:
NUM_MASTERS, 2, number of requesting ports (2..8).
TIMEOUT_CYCLES, 1024, WAIT-state cycles before a transaction is force-completed (used only with UART_ARB_TIMEOUT_EN).
ERR_RDATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
m_valid  in  NUM_MASTERS  per-master request; held until its m_ready
m_instr  in  NUM_MASTERS  per-master instr flag, forwarded unchanged
m_addr  in  32*NUM_MASTERS  packed addresses, master i at [32i+:32]
m_wdata  in  32*NUM_MASTERS  packed write data
m_wstrb  in  4*NUM_MASTERS  packed write strobes
m_ready  out  NUM_MASTERS  one-cycle completion pulse to the granted master
m_rdata  out  32  read data, valid only in m_ready cycle, shared by all masters
s_mem_valid  out  1  slave strobe, exactly one cycle per transaction
s_mem_instr  out  1  forwarded instr flag
s_mem_addr  out  32  latched address
s_mem_wdata  out  32  latched write data
s_mem_wstrb  out  4  latched strobes
s_mem_ready  in  1  slave ready (registered in slave)
s_mem_rdata  in  32  slave read data
grant_id  out  clog2(NUM_MASTERS)  index of current/last granted master
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky timeout flag (tied 0 without UART_ARB_TIMEOUT_EN)

Behaviour:
- Reset state: state=IDLE; m_ready=0, s_mem_valid=0, s_mem_* latches=0, m_rdata=0, grant_id=0, rr pointer=0, timeout_err=0, busy=0.
- Reset mid-transaction aborts it. No m_ready is issued, and the master re-requests after reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any m_valid is high, pick the first requester at or after rr pointer, scanning upward modulo NUM_MASTERS. Latch that master's addr/wdata/wstrb/instr into s_mem_*, set grant_id, go to ISSUE. If no m_valid is high, stay in IDLE.
- ISSUE: s_mem_valid=1 for this one cycle only, then go to WAIT. s_mem_ready is ignored in ISSUE.
- WAIT: s_mem_valid=0. On s_mem_ready=1, capture s_mem_rdata into m_rdata and go to RESP.
- RESP: m_ready[grant_id]=1 for one cycle. Set rr pointer = grant_id+1 (wrapping at NUM_MASTERS). Return to IDLE.
- Latency against uart_mmio: request seen in IDLE at cycle 0, strobe at cycle 1, slave ready at cycle 2, m_ready at cycle 3. Minimum 4 cycles per transaction, back-to-back.
- A master's m_valid dropping while granted is ignored; the latched transaction completes.
- Non-granted masters see m_ready=0 throughout.
- A request from the master just served in RESP is not seen in the same cycle. It competes in the next IDLE at the lowest rotating priority.
- Simultaneous requests are never lost; each is served in rotation. With N masters continuously requesting, worst-case wait is N-1 transactions.
- Write transactions return m_rdata as captured from the slave (0 for uart_mmio writes).

Optional Feature:
UART_ARB_TIMEOUT_EN:
- Defined: a counter is cleared on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES-1 without s_mem_ready, the FSM goes to RESP with m_rdata=ERR_RDATA and sets timeout_err. timeout_err clears only on reset. A late s_mem_ready arriving in IDLE is ignored.
- Undefined: WAIT holds indefinitely, no counter logic is built, timeout_err is tied to 0.

Decomposition:
- Package uart_arb_pkg: FSM state encoding (2 bits: IDLE=0, ISSUE=1, WAIT=2, RESP=3), ERR_RDATA default, helper function for the grant-index width.
- One sub-module, uart_arb_rr_pick: combinational rotating-priority encoder taking (req vector, pointer) and producing (found, index). It is reusable by a future DMA channel scheduler.

Test Plan:
- Single master 0 reads BASE+0x08 (STATUS), slave returns 0x22 → s_mem_valid high exactly 1 cycle; m_ready[0] 3 cycles after request; m_rdata=0x22.
- Masters 0 and 1 both request from reset (writes 0x41, 0x42 to BASE+0x00) → grant order 0 then 1; UART TX FIFO receives 0x41, 0x42 exactly once each.
- Both masters request continuously for 6 transactions → grants alternate 0,1,0,1,0,1; no m_ready overlap.
- Master 1 reads BASE+0x04 with RX FIFO holding 0x55, 0x66 → one pop only, m_rdata=0x55; next read returns 0x66.
- Assert resetn=0 during WAIT → next cycle state IDLE, busy=0, no m_ready pulse.
- UART_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and the slave ready tied 0 → m_ready after 8 WAIT cycles, m_rdata=0xDEADBEEF, timeout_err=1 and stays set.
